pc_call_stack: RTL and testbench
================================

// Module: pc_call_stack
// PURPOSE
//  Parametrised program counter with a hardware return-address stack; successor to
//  the fixed-width combinational gate library, adding registered state and priority control.
//  Drives the instruction-memory address in the CPU. Supports jump (load), call (push+jump)
//  and return (pop) in one cycle each.
// PARAMETERS
//  WIDTH      16  address width in bits; out and all stack entries are WIDTH bits
//  DEPTH      8   return-stack entries (>=1)
//  RESET_VEC  0   value loaded into out on reset
// PORTS
//  clock      in   1                     rising-edge clock
//  reset      in   1                     synchronous, active-high
//  load       in   1                     out <= addr
//  inc        in   1                     out <= out+1
//  call       in   1                     push out+1, then out <= addr
//  ret        in   1                     out <= stack top, then pop
//  addr       in   WIDTH                 jump/call target
//  out        out  WIDTH                 current PC (registered)
//  sp         out  $clog2(DEPTH+1)       stack occupancy, 0..DEPTH
//  full       out  1                     sp==DEPTH (combinational from sp)
//  empty      out  1                     sp==0 (combinational from sp)
//  err        out  1                     sticky over/underflow flag
// BEHAVIOUR
//  - Reset: out=RESET_VEC, sp=0, err=0, stack contents don't-care; reset overrides all inputs,
//    including mid-call/ret.
//  - All updates on rising clock; new out/sp/err visible the cycle after the request (1-cycle latency).
//  - Priority per cycle: reset > ret > call > load > inc > hold. Lower requests in the same
//    cycle are ignored entirely (no partial effects).
//  - inc: out <= (out+1) mod 2^WIDTH; 0xFFFF (WIDTH=16) wraps to 0x0000.
//  - call, not full: stack[sp] <= (out+1) mod 2^WIDTH; sp <= sp+1; out <= addr.
//  - call, full: overflow; err <= 1; out, sp, stack unchanged.
//  - ret, not empty: out <= stack[sp-1]; sp <= sp-1.
//  - ret, empty: underflow; err <= 1; out, sp unchanged.
//  - err is sticky; cleared only by reset. It does not block later valid operations.
//  - No other state machine; the stack is a LIFO indexed by sp; no combinational path from
//    inputs to out.
// STRUCTURE
//  - Shared header pc_defs.vh: op-select localparams OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET
//    and the priority encoder function mapping {ret,call,load,inc} to an op.
//  - One sub-module: lifo_stack #(WIDTH, DEPTH) with push, pop, din, top, count; synchronous
//    reset clears count only. pc_call_stack holds the out/err registers and priority decode.
// TESTING
//  1. reset=1 one cycle -> out=0, sp=0, empty=1, full=0, err=0.
//  2. inc held 3 cycles from 0 -> out=1,2,3; load addr=0x0040 -> out=0x0040 next cycle.
//  3. out=0xFFFF, inc -> out=0x0000, err stays 0.
//  4. out=0x0005, call addr=0x0100 -> out=0x0100, sp=1; ret -> out=0x0006, sp=0.
//  5. DEPTH=8: 9 consecutive calls -> after 8th full=1; 9th: err=1, sp=8, out unchanged;
//     then 8 rets unwind in LIFO order; 9th ret: err stays 1, out unchanged.
//  6. ret+call+load+inc same cycle with sp=1 -> only ret acts; then with sp=3, assert reset
//     alongside call -> out=RESET_VEC, sp=0, err=0.

Source files
------------

// File: rtl/pc_call_stack_pkg.sv
// Purpose : shared op-select encoding and request priority encoder for the PC / return stack.
// Latency : n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   op_t       - operation selected for one cycle (hold, inc, load, call, ret)
//   op_select  - maps the raw {ret, call, load, inc} requests to a single op,
//                highest priority first: ret > call > load > inc > hold
package pc_call_stack_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_LOAD = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_t;

    // Exactly one op wins per cycle, so lower-priority requests that arrive in
    // the same cycle have no partial effect anywhere in the datapath.
    function automatic op_t op_select(
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        op_t op;
        op = OP_HOLD;
        if (ret) begin
            op = OP_RET;
        end else if (call) begin
            op = OP_CALL;
        end else if (load) begin
            op = OP_LOAD;
        end else if (inc) begin
            op = OP_INC;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_call_stack_lifo_stack.sv
// Purpose : LIFO of return addresses indexed by its occupancy count.
// Latency : push/pop take effect on the next rising edge; top is combinational from count/storage.
// Backpressure: none; push when full and pop when empty are ignored (caller flags them).
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; clears count only, storage is left as-is
//   push   - write din at entry [count], count+1
//   pop    - count-1 (top moves to the previous entry)
//   din    - value to push
//   top    - entry [count-1]; meaningless while count==0
//   count  - occupancy, 0..DEPTH
module lifo_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             is_full;
    logic             is_empty;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    top_idx;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    assign is_full  = (count == CW'(DEPTH));
    assign is_empty = (count == '0);

    // Guard locally too, so the storage can never be corrupted by a push
    // beyond the last entry even if the caller misbehaves.
    assign do_push  = push && !pop && !is_full;
    assign do_pop   = pop && !push && !is_empty;

    assign top_idx  = count - CW'(1);
    assign wr_addr  = count[AW-1:0];
    assign rd_addr  = top_idx[AW-1:0];
    assign top      = mem[rd_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CW'(1);
        end else if (do_pop) begin
            count <= count - CW'(1);
        end
    end

    // Storage carries no reset: contents are don't-care until pushed.
    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_addr] <= din;
        end
    end

endmodule

// File: rtl/pc_call_stack.sv
// Purpose : program counter with hardware return-address stack (jump, call, return, increment).
// Latency : one cycle; out/sp/err reflect a request on the edge that samples it. No input-to-out path.
// Backpressure: none; call when full / ret when empty set the sticky err and leave state unchanged.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; out=RESET_VEC, sp=0, err=0; overrides every request
//   load   - out <= addr
//   inc    - out <= out+1 (wraps modulo 2^WIDTH)
//   call   - push out+1, out <= addr
//   ret    - out <= stack top, pop
//   addr   - jump / call target
//   out    - current PC (registered)
//   sp     - stack occupancy 0..DEPTH
//   full   - sp==DEPTH
//   empty  - sp==0
//   err    - sticky overflow/underflow flag, cleared only by reset
module pc_call_stack
    import pc_call_stack_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    sp,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    op_t              op;
    logic             push;
    logic             pop;
    logic             overflow;
    logic             underflow;
    logic [WIDTH-1:0] out_plus1;
    logic [WIDTH-1:0] stack_top;

    assign full      = (sp == CW'(DEPTH));
    assign empty     = (sp == '0);
    assign out_plus1 = out + ONE;

    // Decode the single winning op, then derive the stack strobes from it so a
    // rejected call/ret never touches the stack.
    always_comb begin
        op        = op_select(ret, call, load, inc);
        push      = 1'b0;
        pop       = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        case (op)
            OP_CALL: begin
                push     = !full;
                overflow = full;
            end
            OP_RET: begin
                pop       = !empty;
                underflow = empty;
            end
            default: begin
            end
        endcase
    end

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (out_plus1),
        .top   (stack_top),
        .count (sp)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out <= RESET_VEC;
        end else begin
            case (op)
                OP_INC:  out <= out_plus1;
                OP_LOAD: out <= addr;
                OP_CALL: if (push) out <= addr;
                OP_RET:  if (pop)  out <= stack_top;
                default: out <= out;
            endcase
        end
    end

    // Sticky: once set only reset clears it; later valid ops proceed normally.
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (overflow || underflow) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_call_stack.sv
// Purpose : directed-vector scoreboard bench for pc_call_stack (WIDTH=16, DEPTH=8, RESET_VEC=0).
// Latency : each vector's expected state is checked one edge after it is driven.
// Backpressure: n/a.
module tb_pc_call_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    // Request bit positions in a vector's op field: {reset, ret, call, load, inc}
    localparam logic [4:0] R_INC  = 5'b00001;
    localparam logic [4:0] R_LOAD = 5'b00010;
    localparam logic [4:0] R_CALL = 5'b00100;
    localparam logic [4:0] R_RET  = 5'b01000;
    localparam logic [4:0] R_RST  = 5'b10000;
    localparam logic [4:0] R_NONE = 5'b00000;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] out;
        logic [CW-1:0]    sp;
        logic             full;
        logic             empty;
        logic             err;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             load  = 1'b0;
    logic             inc   = 1'b0;
    logic             call  = 1'b0;
    logic             ret   = 1'b0;
    logic [WIDTH-1:0] addr  = '0;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    sp;
    logic             full;
    logic             empty;
    logic             err;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   done   = 1'b0;

    pc_call_stack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VEC (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .inc   (inc),
        .call  (call),
        .ret   (ret),
        .addr  (addr),
        .out   (out),
        .sp    (sp),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    always #5 clock = ~clock;

    // Drive one vector on the falling edge and queue what the next rising edge must produce.
    task automatic step(input string name, input logic [4:0] req, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] e_out, input int e_sp, input logic e_err);
        exp_t e;
        @(negedge clock);
        reset = req[4];
        ret   = req[3];
        call  = req[2];
        load  = req[1];
        inc   = req[0];
        addr  = a;
        e.name  = name;
        e.out   = e_out;
        e.sp    = CW'(e_sp);
        e.full  = (e_sp == DEPTH);
        e.empty = (e_sp == 0);
        e.err   = e_err;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, check the oldest outstanding vector.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (out !== e.out || sp !== e.sp || full !== e.full ||
                    empty !== e.empty || err !== e.err) begin
                    n_miss++;
                    $display("FAIL %s: got out=%h sp=%0d full=%b empty=%b err=%b, want out=%h sp=%0d full=%b empty=%b err=%b",
                             e.name, out, sp, full, empty, err,
                             e.out, e.sp, e.full, e.empty, e.err);
                end
            end
        end
    end

    initial begin
        // 1. reset
        step("reset", R_RST, 16'h0000, 16'h0000, 0, 1'b0);
        step("hold_after_reset", R_NONE, 16'h1234, 16'h0000, 0, 1'b0);

        // 2. increment and load
        step("inc1", R_INC, 16'h0000, 16'h0001, 0, 1'b0);
        step("inc2", R_INC, 16'h0000, 16'h0002, 0, 1'b0);
        step("inc3", R_INC, 16'h0000, 16'h0003, 0, 1'b0);
        step("load_0040", R_LOAD, 16'h0040, 16'h0040, 0, 1'b0);
        step("load_beats_inc", R_LOAD | R_INC, 16'h0077, 16'h0077, 0, 1'b0);

        // 3. wrap
        step("load_ffff", R_LOAD, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        step("inc_wrap", R_INC, 16'h0000, 16'h0000, 0, 1'b0);

        // 4. call / ret round trip
        step("load_0005", R_LOAD, 16'h0005, 16'h0005, 0, 1'b0);
        step("call_0100", R_CALL, 16'h0100, 16'h0100, 1, 1'b0);
        step("ret_to_0006", R_RET, 16'h0000, 16'h0006, 0, 1'b0);

        // 5. fill, overflow, unwind, underflow (out=0x0006 here).
        //    Call k targets 0x1000+0x10k; stack[0]=0x0007, stack[m]=0x1000+0x10m+1.
        for (int k = 1; k <= DEPTH; k++) begin
            step($sformatf("fill_call%0d", k), R_CALL, 16'(16'h1000 + 16'h10 * k),
                 16'(16'h1000 + 16'h10 * k), k, 1'b0);
        end
        step("overflow_call", R_CALL, 16'h2000, 16'h1080, 8, 1'b1);
        for (int j = 1; j <= DEPTH; j++) begin
            step($sformatf("unwind_ret%0d", j), R_RET, 16'h0000,
                 (j == DEPTH) ? 16'h0007 : 16'(16'h1000 + 16'h10 * (DEPTH - j) + 1),
                 DEPTH - j, 1'b1);
        end
        step("underflow_ret", R_RET, 16'h0000, 16'h0007, 0, 1'b1);
        step("err_sticky_inc", R_INC, 16'h0000, 16'h0008, 0, 1'b1);

        // 6. priority and reset override
        step("reset_clears_err", R_RST, 16'h0000, 16'h0000, 0, 1'b0);
        step("call_beats_load", R_CALL | R_LOAD | R_INC, 16'h0600, 16'h0600, 1, 1'b0);
        step("ret_beats_all", R_RET | R_CALL | R_LOAD | R_INC, 16'h0500, 16'h0001, 0, 1'b0);
        step("call_0010", R_CALL, 16'h0010, 16'h0010, 1, 1'b0);
        step("call_0020", R_CALL, 16'h0020, 16'h0020, 2, 1'b0);
        step("call_0030", R_CALL, 16'h0030, 16'h0030, 3, 1'b0);
        step("reset_beats_call", R_RST | R_CALL, 16'h0040, 16'h0000, 0, 1'b0);
        step("reset_beats_ret", R_RST | R_RET, 16'h0000, 16'h0000, 0, 1'b0);

        @(negedge clock);
        {reset, ret, call, load, inc} = R_NONE;

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clock);
        end
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
